// File: rtl/nios_isa_pkg.sv
// NIOS II ISA constants and instruction-fetch state encoding.
// Shared by the fetch unit and its next-PC helper.
package nios_isa_pkg;

  localparam logic [5:0] OP_BR  = 6'h06;
  localparam logic [5:0] OP_BLT = 6'h16;
  localparam logic [5:0] OP_LDW = 6'h17;
  localparam logic [5:0] OP_STW = 6'h15;
  localparam logic [5:0] OP_ORI = 6'h14;

  localparam int OPC_MSB = 5;
  localparam int OPC_LSB = 0;
  localparam int IMM_MSB = 21;
  localparam int IMM_LSB = 6;
  localparam int A_MSB   = 31;
  localparam int A_LSB   = 27;
  localparam int B_MSB   = 26;
  localparam int B_LSB   = 22;

  typedef logic [1:0] ifu_state_t;

  localparam ifu_state_t S_FETCH = 2'd0;
  localparam ifu_state_t S_WAIT  = 2'd1;
  localparam ifu_state_t S_HOLD  = 2'd2;
  localparam ifu_state_t S_DRAIN = 2'd3;

  function automatic logic is_br(input logic [31:0] inst);
    return inst[OPC_MSB:OPC_LSB] == OP_BR;
  endfunction

  function automatic logic [15:0] imm16(input logic [31:0] inst);
    return inst[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory port, decode handshake and redirect.
// master = fetch unit, slave = memory/decode side.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;
  logic [31:0]       inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic              inst_valid;
  logic              inst_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    output inst_out, pc_out, inst_valid,
    input  imem_rdata, imem_valid,
    input  inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    input  inst_out, pc_out, inst_valid,
    output imem_rdata, imem_valid,
    output inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifu_pc_next.sv
// Next-PC select: redirect target, br target or sequential pc+4.
// Targets are word-aligned; arithmetic wraps modulo 2^ADDR_W.
module ifu_pc_next
  import nios_isa_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [31:0]       i_inst,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_pc_next
);

  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(3);

  logic [15:0]       w_imm;
  logic [ADDR_W-1:0] w_sext;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_br;

  assign w_imm  = imm16(i_inst);
  assign w_sext = {{(ADDR_W-16){w_imm[15]}}, w_imm};
  assign w_seq  = i_pc + ADDR_W'(4);
  assign w_br   = (w_seq + w_sext) & MASK;

  always_comb begin
    o_pc_next = w_seq;
    unique case (1'b1)
      i_redirect:     o_pc_next = i_redirect_pc & MASK;
      is_br(i_inst):  o_pc_next = w_br;
      default:        o_pc_next = w_seq;
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request,
// holds each word until decode takes it; resolves br locally.
module inst_fetch_unit
  import nios_isa_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clock,
  input logic               reset,
  inst_fetch_unit_if.master bus
);

  ifu_state_t        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_pc_out;
  logic              r_valid;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;

  logic [ADDR_W-1:0] w_pc_next;
  logic              w_fetch;
  logic              w_wait;
  logic              w_hold;
  logic              w_drain;

  assign w_fetch = r_state == S_FETCH;
  assign w_wait  = r_state == S_WAIT;
  assign w_hold  = r_state == S_HOLD;
  assign w_drain = r_state == S_DRAIN;

  ifu_pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .i_pc          (r_pc),
    .i_inst        (r_inst),
    .i_redirect    (bus.redirect),
    .i_redirect_pc (bus.redirect_pc),
    .o_pc_next     (w_pc_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_inst   <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc    <= w_pc_next;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      unique case (1'b1)
        w_fetch: begin
          // a request already on the bus is still owed a response
          if (r_req) begin
            r_state <= S_DRAIN;
          end else begin
            r_req  <= 1'b1;
            r_addr <= w_pc_next;
          end
        end
        w_wait, w_drain: begin
          if (bus.imem_valid) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_addr  <= w_pc_next;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        w_hold: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          r_addr  <= w_pc_next;
        end
        default: r_state <= S_FETCH;
      endcase
    end else begin
      unique case (1'b1)
        w_fetch: begin
          // after reset FETCH first raises the request, then moves on
          if (r_req) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_req  <= 1'b1;
            r_addr <= r_pc;
          end
        end
        w_wait: begin
          if (bus.imem_valid) begin
            r_inst   <= bus.imem_rdata;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_state  <= S_HOLD;
          end
        end
        w_hold: begin
          if (bus.inst_ready) begin
            r_valid <= 1'b0;
            r_pc    <= w_pc_next;
            r_req   <= 1'b1;
            r_addr  <= w_pc_next;
            r_state <= S_FETCH;
          end
        end
        w_drain: begin
          if (bus.imem_valid) begin
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_addr;
  assign bus.inst_out   = r_inst;
  assign bus.pc_out     = r_pc_out;
  assign bus.inst_valid = r_valid;

endmodule
